// File: rtl/seq_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : seq_serializer
//  Function : Parallel-to-serial front end for the two-sequence detector.
//             Accepts WIDTH-bit words over valid/ready, shifts them onto the
//             single-bit x stream with no gaps between back-to-back words,
//             and keeps one word queued in a hold buffer.
//  Revision : 1.0  initial release
// ============================================================================
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int IDLE_BIT  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_one  = CW'(1);
  localparam logic          c_idle = (IDLE_BIT != 0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic             r_x;
  logic             r_x_valid;
  logic             r_word_done;

  logic             w_accept;
  logic [WIDTH-1:0] w_load_word;
  logic             w_load_first;
  logic [WIDTH-1:0] w_load_rest;
  logic             w_head;
  logic [WIDTH-1:0] w_shift_next;
  logic [CW-1:0]    w_cnt_inc;

  // The hold buffer is the only thing that can refuse a word, so ready is
  // purely a function of its flag and never loops back from data_valid.
  assign data_ready = ~r_hold_full;
  assign w_accept   = data_valid & ~r_hold_full;
  assign busy       = (r_state == ST_SHIFT) | r_hold_full;
  assign x          = r_x;
  assign x_valid    = r_x_valid;
  assign word_done  = r_word_done;
  assign w_cnt_inc  = r_bit_cnt + c_one;

  // A held word always has priority over the input port when a new word is
  // loaded; in IDLE the hold buffer is necessarily empty.
  assign w_load_word = r_hold_full ? r_hold : data_in;

  // Bit order: the first bit goes straight to x on load, and the shift
  // register keeps the remaining bits with the next one at its head.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_load_first = w_load_word[WIDTH-1];
      assign w_load_rest  = {w_load_word[WIDTH-2:0], 1'b0};
      assign w_head       = r_shift[WIDTH-1];
      assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_load_first = w_load_word[0];
      assign w_load_rest  = {1'b0, w_load_word[WIDTH-1:1]};
      assign w_head       = r_shift[0];
      assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // Control FSM, shifter, hold buffer and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_x         <= c_idle;
      r_x_valid   <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift     <= w_load_rest;
            r_x         <= w_load_first;
            r_x_valid   <= 1'b1;
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
            r_state     <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (r_bit_cnt != c_last) begin
            // Mid-word: advance one bit, queue an offered word in the hold.
            r_x         <= w_head;
            r_shift     <= w_shift_next;
            r_bit_cnt   <= w_cnt_inc;
            r_word_done <= (w_cnt_inc == c_last);
            if (w_accept) begin
              r_hold      <= data_in;
              r_hold_full <= 1'b1;
            end
          end else if (r_hold_full) begin
            // Last bit on x: the held word follows with no gap.
            r_shift     <= w_load_rest;
            r_x         <= w_load_first;
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
            r_hold_full <= 1'b0;
          end else if (w_accept) begin
            // Last bit on x and a word arrives now: bypass the hold buffer.
            r_shift     <= w_load_rest;
            r_x         <= w_load_first;
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
          end else begin
            r_x         <= c_idle;
            r_x_valid   <= 1'b0;
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial front end for the two-sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and drives them onto the detector's single-bit `x` input, one bit per clock, with no gaps between back-to-back words. A one-word hold buffer lets the producer queue the next word while the current one is shifting. When no data is pending, `x` rests at a programmable idle level.

## Interface
- `WIDTH`, default 8: word length in bits; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- `IDLE_BIT`, default 0: value driven on `x` when no word is shifting.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset. It clears all state immediately.
- `data_in`  in  WIDTH  word to serialize.
- `data_valid`  in  1  the producer offers `data_in` this cycle.
- `data_ready`  out  1  the block can accept a word this cycle.
- `x`  out  1  serial bit stream to the sequence detector (registered).
- `x_valid`  out  1  `x` carries a data bit, not the idle level (registered).
- `word_done`  out  1  one-cycle pulse while the last bit of a word is on `x` (registered).
- `busy`  out  1  shifter active or hold buffer occupied.

## Operation
- Internal state:
  - State machine with two states: IDLE and SHIFT.
  - WIDTH-bit shift register.
  - Bit counter `bit_cnt`, 0..WIDTH-1, giving the index within the word of the bit currently on `x`.
  - Hold register plus a `hold_full` flag.
- Values during reset and immediately after it:
  - `x` = IDLE_BIT; `x_valid` = 0; `word_done` = 0; `busy` = 0.
  - `data_ready` = 1; state = IDLE; `bit_cnt` = 0; `hold_full` = 0.
- `data_ready` = !`hold_full`. It is derived only from register state and never depends on `data_valid`.
- An accept happens on any rising edge where `data_valid` and `data_ready` are both 1.
- IDLE + accept:
  - The word loads into the shift register.
  - First bit goes to `x`; `x_valid` = 1; `bit_cnt` = 0.
  - State → SHIFT.
- SHIFT, not the last bit (`bit_cnt` < WIDTH-1):
  - The next bit goes to `x`; `bit_cnt` increments.
  - An accept in this case loads the hold register and sets `hold_full`.
- SHIFT, last bit (`bit_cnt` = WIDTH-1), priority order:
  1. If `hold_full`: the hold word moves to the shift register, its first bit goes to `x`, and `hold_full` clears. No accept is possible on this edge because `data_ready` = 0.
  2. Otherwise, on an accept: the offered word goes straight to the shift register, not to the hold register.
  3. Otherwise: `x` = IDLE_BIT, `x_valid` = 0, state → IDLE.
- `word_done` = 1 exactly for the cycle in which `bit_cnt` = WIDTH-1 and `x_valid` = 1.
- `busy` = (state == SHIFT) | `hold_full`.
- `data_in` is sampled only on an accept edge. Changes at any other time have no effect.

## Timing
- Latency: a word accepted at edge N shows its first bit on `x` from edge N (IDLE case) and its last bit from edge N+WIDTH-1. The detector samples that first bit at edge N+1.
- Back-to-back words: the first bit of word k+1 follows the last bit of word k on the very next cycle. `x_valid` stays 1 throughout.
- Hold-buffer refill:
  - When the hold word transfers at the last-bit edge E, `data_ready` returns to 1 in the cycle after E.
  - The producer can therefore sustain one word per WIDTH cycles with no bubble.
- Reset asserted mid-word:
  - `x`, `x_valid`, `word_done`, `busy` and `data_ready` take their reset values asynchronously, without waiting for a clock edge.
  - The partial word and any held word are discarded.
- Reset deassertion:
  - The first accept is possible on the first rising edge after `reset` falls.
  - No output changes until that accept.

## Test plan
- Reset, then one word 8'b1011_0100 with MSB_FIRST=1:
  - `x` = 1,0,1,1,0,1,0,0 on eight consecutive cycles.
  - `word_done` pulses in the 8th cycle.
  - Then `x` = IDLE_BIT and `x_valid` = 0.
- Three words 8'hA5, 8'h3C, 8'hFF offered continuously with `data_valid` held high:
  - 24 contiguous valid bits with no idle gap.
  - `data_ready` drops after the second accept and rises again one cycle after each transfer.
- Word offered exactly on the last-bit edge with the hold buffer empty:
  - It goes straight into the shifter; no gap appears.
  - `hold_full` stays 0.
- MSB_FIRST=0 with 8'b0000_0001:
  - `x` = 1,0,0,0,0,0,0,0.
- `reset` pulsed high mid-word (after 3 bits), with a word held:
  - All outputs return to their reset values immediately, without a clock edge.
  - After release, a new word 8'hC3 serializes from its first bit; no remnant of the old or held word appears.
- `data_valid` high while `data_ready` = 0:
  - The word is not accepted.
  - The stream matches a reference model that only counts accepts.
